// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem request at a time and
// presents one instruction to decode. Optional perf counters are built when FETCH_PERF_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [1:0]  fsm_state
);

  // Handshake: imem_req stays high with a stable imem_addr until imem_gnt is seen in FETCH;
  // read data is taken only in WAIT; instr is consumed downstream when instr_valid && !stall.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        accept;
  logic [31:0] next_tgt;

  assign accept   = (state_q == S_VALID) && !stall;
  assign next_tgt = (pc_q + imm_ext) & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    case (state_q)
      S_FETCH: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        // Redirect only on the accept cycle; a stalled instruction ignores pc_src/imm_ext.
        if (accept) begin
          fetch_pc_d = pc_src ? next_tgt : (pc_q + 32'd4);
          instr_d    = NOP_INSTR;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (accept) perf_fetched <= perf_fetched + 32'd1;
      if ((state_q == S_VALID) && stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  // Request is masked while reset is asserted so nothing leaves during reset cycles.
  assign imem_req    = rst_n && (state_q == S_FETCH);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_VALID);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/stall/branch/reset vectors, scoreboard queues for
// granted addresses and accepted instructions, plus a second instance with RESET_PC at the wrap point.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] imm_ext = '0;
  logic        sel = 1'b0;

  logic        a_req, b_req, a_valid, b_valid;
  logic [31:0] a_addr, b_addr, a_instr, b_instr, a_pc, b_pc, a_pc4, b_pc4;
  logic [1:0]  a_state, b_state;
`ifdef FETCH_PERF_EN
  logic [31:0] a_pf, a_ps, b_pf, b_ps;
`endif

  logic        m_req, m_valid;
  logic [31:0] m_addr, m_instr, m_pc, m_pc4;

  logic [31:0] exp_addr_q[$];
  logic [95:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(a_instr), .instr_valid(a_valid),
    .pc(a_pc), .pc_plus4(a_pc4), .stall(stall), .pc_src(pc_src), .imm_ext(imm_ext),
`ifdef FETCH_PERF_EN
    .perf_fetched(a_pf), .perf_stall(a_ps),
`endif
    .fsm_state(a_state)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(b_instr), .instr_valid(b_valid),
    .pc(b_pc), .pc_plus4(b_pc4), .stall(stall), .pc_src(pc_src), .imm_ext(imm_ext),
`ifdef FETCH_PERF_EN
    .perf_fetched(b_pf), .perf_stall(b_ps),
`endif
    .fsm_state(b_state)
  );

  always_comb begin
    m_req   = sel ? b_req   : a_req;
    m_addr  = sel ? b_addr  : a_addr;
    m_valid = sel ? b_valid : a_valid;
    m_instr = sel ? b_instr : a_instr;
    m_pc    = sel ? b_pc    : a_pc;
    m_pc4   = sel ? b_pc4   : a_pc4;
  end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: granted request addresses
  always @(negedge clk) begin
    if (m_req && imem_gnt) begin
      if (exp_addr_q.size() == 0) chk("unexpected_gnt_addr", {64'd0, m_addr}, 96'hFFFF_FFFF);
      else chk("imem_addr", {64'd0, m_addr}, {64'd0, exp_addr_q.pop_front()});
    end
  end

  // Monitor: accepted instructions
  always @(negedge clk) begin
    if (m_valid && !stall) begin
      if (exp_q.size() == 0) chk("unexpected_instr", {m_instr, m_pc, m_pc4}, '1);
      else chk("instr_pc_pc4", {m_instr, m_pc, m_pc4}, exp_q.pop_front());
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("reset_state", {m_req, m_valid, m_instr}, {1'b0, 1'b0, NOP});
    end
    rst_n = 1'b1;
  endtask

  task automatic fetch_one(input int gdly, input logic [31:0] data, input logic [31:0] addr);
    int n = 0;
    exp_addr_q.push_back(addr);
    while (!m_req && n < 50) begin @(posedge clk); #1; n++; end
    if (!m_req) begin chk("req_timeout", {95'd0, m_req}, 96'd1); return; end
    for (int i = 0; i < gdly; i++) begin
      imem_rvalid = 1'b1;           // stray response outside WAIT must be ignored
      imem_rdata  = 32'hDEAD_BEEF;
      chk("req_hold", {m_req, m_valid, m_addr}, {1'b1, 1'b0, addr});
      @(posedge clk); #1;
    end
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    chk("wait_state", {m_req, m_valid}, 2'b00);
    exp_q.push_back({data, addr, addr + 32'd4});
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic consume(input int sn, input logic src, input logic [31:0] imm,
                         input logic [31:0] ei, input logic [31:0] ep);
    int n = 0;
    while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!m_valid) begin chk("valid_timeout", {95'd0, m_valid}, 96'd1); return; end
    for (int i = 0; i < sn; i++) begin
      stall = 1'b1;
      pc_src = 1'b1;
      imm_ext = 32'h0000_0100;
      @(posedge clk); #1;
      chk("stall_hold", {m_valid, m_instr, m_pc, m_req}, {1'b1, ei, ep, 1'b0});
    end
    stall = 1'b0;
    pc_src = src;
    imm_ext = imm;
    @(posedge clk); #1;
    pc_src = 1'b0;
    imm_ext = '0;
    chk("clear_on_accept", {m_valid, m_instr}, {1'b0, NOP});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset(3);
    fetch_one(0, 32'h0050_0093, 32'h0000_0000);
    consume(0, 1'b0, 32'h0, 32'h0050_0093, 32'h0000_0000);
    fetch_one(3, 32'h00A0_0113, 32'h0000_0004);
    consume(0, 1'b0, 32'h0, 32'h00A0_0113, 32'h0000_0004);
    fetch_one(0, 32'h0000_0193, 32'h0000_0008);
    consume(4, 1'b0, 32'h0, 32'h0000_0193, 32'h0000_0008);
    fetch_one(0, 32'h0030_0213, 32'h0000_000C);
    consume(0, 1'b0, 32'h0, 32'h0030_0213, 32'h0000_000C);
    fetch_one(0, 32'h0000_0063, 32'h0000_0010);
    consume(0, 1'b1, 32'h0000_0006, 32'h0000_0063, 32'h0000_0010);
    fetch_one(0, 32'hFE00_0EE3, 32'h0000_0014);
    consume(0, 1'b1, 32'hFFFF_FFFC, 32'hFE00_0EE3, 32'h0000_0014);
    fetch_one(0, 32'hFE00_08E3, 32'h0000_0010);
    consume(0, 1'b1, 32'hFFFF_FFF0, 32'hFE00_08E3, 32'h0000_0010);
    fetch_one(0, 32'h0010_0293, 32'h0000_0000);
    consume(0, 1'b0, 32'h0, 32'h0010_0293, 32'h0000_0000);

    // Reset while WAIT: the late response must be dropped.
    n = 0;
    while (!m_req && n < 50) begin @(posedge clk); #1; n++; end
    exp_addr_q.push_back(32'h0000_0004);
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_wait", {m_req, m_valid}, 2'b00);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0093;
    @(posedge clk); #1;
    chk("rst_rvalid_ignored", {m_req, m_valid, m_instr}, {1'b0, 1'b0, NOP});
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("post_reset_req", {m_req, m_valid, m_addr}, {1'b1, 1'b0, 32'h0000_0000});
    fetch_one(0, 32'h0070_0313, 32'h0000_0000);
    consume(0, 1'b0, 32'h0, 32'h0070_0313, 32'h0000_0000);

    // Second instance: RESET_PC at the top of the address space.
    sel = 1'b1;
    do_reset(2);
    fetch_one(0, 32'h0000_0073, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", {64'd0, m_pc4}, 96'd0);
    consume(1, 1'b0, 32'h0, 32'h0000_0073, 32'hFFFF_FFFC);
    fetch_one(0, 32'h0010_0073, 32'h0000_0000);
    consume(0, 1'b0, 32'h0, 32'h0010_0073, 32'h0000_0000);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", {64'd0, b_pf}, 96'd2);
    chk("perf_stall", {64'd0, b_ps}, 96'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("addr_queue_empty", 96'(exp_addr_q.size()), 96'd0);
    chk("instr_queue_empty", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
